instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
// Encodes instruction descriptors (kind + register/immediate fields) into 32-bit MIPS words and
// streams them into program memory at consecutive word addresses. It sits between the bench or
// boot source and the instruction ROM/RAM write port, and is the encoding counterpart of the
// opcode decoder in the control path. It covers the instruction set the core executes, plus LW/SW/BEQ/BNE.
// PARAMETERS
// ADDR_W        6     word-address width of program memory
// MEMORY_DEPTH  64    words available; MEMORY_DEPTH <= 2**ADDR_W
// PORTS
// clk        in   1         rising-edge clock
// reset      in   1         asynchronous, active-low; clears all state
// start      in   1         1-cycle pulse: clear pointer/flags, enter LOAD
// in_valid   in   1         descriptor valid
// in_ready   out  1         descriptor accepted when in_valid & in_ready
// in_kind    in   4         0 ADD,1 SUB,2 AND,3 OR,4 NOR,5 SLT,6 SLL,7 SRL,8 ADDI,9 ORI,10 LUI,
//                           11 LW,12 SW,13 BEQ,14 BNE,15 illegal
// in_rs/in_rt/in_rd/in_shamt  in  5 each   register and shift fields
// in_imm     in   16        immediate / branch offset, passed through unchanged
// in_last    in   1         final descriptor of program
// mem_we     out  1         program memory write strobe
// mem_addr   out  ADDR_W    word address of write
// mem_wdata  out  32        encoded instruction
// count      out  ADDR_W+1  words written since start
// busy       out  1         state == LOAD
// done       out  1         program complete; held until start
// error      out  1         sticky: illegal kind or overflow; cleared by start
// BEHAVIOUR
// - Reset: state IDLE; in_ready, mem_we, busy, done, error = 0; count, mem_addr, mem_wdata = 0.
// - FSM IDLE -start-> LOAD; LOAD -(last beat handled or overflow)-> DONE; DONE -start-> LOAD.
//   start in any state: count=0, done=0, error=0, pending write dropped, state LOAD next cycle.
// - in_ready = (state==LOAD) & ~start & (count + pend < MEMORY_DEPTH); pend = write stage full.
// - Latency 1: beat accepted at cycle N -> mem_we=1 at N+1, mem_addr=count, mem_wdata=word;
//   count increments at end of N+1. mem_we is a single-cycle pulse per written beat.
// - Throughput one beat per cycle; back-to-back beats give consecutive addresses.
// - Encoding: R-type {6'h00,rs,rt,rd,shamt,funct}; funct ADD 20,SUB 22,AND 24,OR 25,NOR 27,
//   SLT 2A,SLL 00,SRL 02 (hex). For ADD..SLT shamt field is forced 0; for SLL/SRL rs is forced 0.
//   I-type {op,rs,rt,imm}; op ADDI 08,ORI 0D,LUI 0F (rs forced 0),LW 23,SW 2B,BEQ 04,BNE 05.
// - Kind 15: beat accepted, nothing written, count unchanged, error=1 next cycle; LOAD continues.
// - in_last on accepted beat: state DONE the cycle its write (or discard) completes; done=1 then.
// - Overflow: in_valid high while count+pend == MEMORY_DEPTH in LOAD with no last seen ->
//   error=1, state DONE, done=1; no write beyond MEMORY_DEPTH-1 ever.
// - Beats in IDLE/DONE are never accepted (in_ready=0).
// - Reset mid-LOAD aborts immediately; pending write is lost, mem_we deasserts asynchronously.
// TESTING
// - reset, start, ADDI rt=8 rs=0 imm=5 -> next cycle mem_we=1, addr 0, wdata 0x20080005, count 1.
// - ADD rd=10 rs=8 rt=9 then LUI rt=1 imm=0x1001 back-to-back -> 0x01095020 @0, 0x3C011001 @1.
// - SLL rd=2 rt=3 shamt=4 rs=7 -> 0x00031100 (rs forced 0); BEQ rs=8 rt=9 imm=0xFFFE -> 0x1109FFFE.
// - SW rt=9 rs=29 imm=4 with in_last -> 0xAFA90004 written, then done=1, busy=0, in_ready=0.
// - MEMORY_DEPTH=4, stream 5 beats no last -> 4 writes addr 0..3, error=1, done=1, count=4.
// - kind 15 mid-stream -> no write, error=1, following ADD written at next address; start clears.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Descriptor stream into the loader and the program-memory write port out of it.
// master = descriptor source / memory sink, slave = the loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes instruction descriptors into 32-bit MIPS words and streams them into
// program memory at consecutive word addresses through a one-deep write stage.
module instr_encoder_loader #(
  parameter int ADDR_W       = 6,
  parameter int MEMORY_DEPTH = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]       count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns {legal, word}; kind 15 is the only illegal encoding.
  function automatic logic [32:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm
  );
    logic [32:0] res;
    case (kind)
      4'd0:    res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd1:    res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd2:    res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'd3:    res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd4:    res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h27};
      4'd5:    res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4'd6:    res = {1'b1, 6'h00, 5'd0, rt, rd, shamt, 6'h00};
      4'd7:    res = {1'b1, 6'h00, 5'd0, rt, rd, shamt, 6'h02};
      4'd8:    res = {1'b1, 6'h08, rs, rt, imm};
      4'd9:    res = {1'b1, 6'h0D, rs, rt, imm};
      4'd10:   res = {1'b1, 6'h0F, 5'd0, rt, imm};
      4'd11:   res = {1'b1, 6'h23, rs, rt, imm};
      4'd12:   res = {1'b1, 6'h2B, rs, rt, imm};
      4'd13:   res = {1'b1, 6'h04, rs, rt, imm};
      4'd14:   res = {1'b1, 6'h05, rs, rt, imm};
      default: res = {1'b0, 32'h0000_0000};
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              error_q, error_d;

  logic [CW-1:0]     pend_s;
  logic [CW-1:0]     fill_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              overflow_s;
  logic [32:0]       enc_s;

  // fill_s counts committed words plus the one sitting in the write stage.
  assign pend_s     = {{ADDR_W{1'b0}}, mem_we_q};
  assign fill_s     = count_q + pend_s;
  assign in_ready_s = (state_q == ST_LOAD) & ~start_i & (fill_s < DEPTH_C);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign overflow_s = (state_q == ST_LOAD) & ~start_i & bus.in_valid & (fill_s == DEPTH_C);
  assign enc_s      = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                             bus.in_shamt, bus.in_imm);

  // Next-state, write-stage and status computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q + pend_s;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = error_q;
    if (start_i) begin
      state_d = ST_LOAD;
      count_d = '0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept_s) begin
            if (enc_s[32]) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = fill_s[ADDR_W-1:0];
              mem_wdata_d = enc_s[31:0];
            end else begin
              error_d = 1'b1;
            end
            if (bus.in_last) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOAD;
            end
          end else if (overflow_s) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and write-stage registers; reset also kills any pending write.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign count_o       = count_q;
  assign busy_o        = (state_q == ST_LOAD);
  assign done_o        = (state_q == ST_DONE);
  assign error_o       = error_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader: a 64-word and a 4-word
// instance checked cycle by cycle against a program-level reference model.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        sel;
  logic        tb_start, tb_valid, tb_last;
  logic [3:0]  tb_kind;
  logic [4:0]  tb_rs, tb_rt, tb_rd, tb_sh;
  logic [15:0] tb_imm;

  instr_encoder_loader_if #(.ADDR_W(6)) bus_a();
  instr_encoder_loader_if #(.ADDR_W(2)) bus_b();

  logic [6:0] cnt_a;
  logic [2:0] cnt_b;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic start_a, start_b;

  assign start_a = tb_start & ~sel;
  assign start_b = tb_start & sel;
  assign bus_a.in_valid = tb_valid & ~sel;
  assign bus_b.in_valid = tb_valid & sel;
  assign bus_a.in_kind = tb_kind;   assign bus_b.in_kind = tb_kind;
  assign bus_a.in_rs = tb_rs;       assign bus_b.in_rs = tb_rs;
  assign bus_a.in_rt = tb_rt;       assign bus_b.in_rt = tb_rt;
  assign bus_a.in_rd = tb_rd;       assign bus_b.in_rd = tb_rd;
  assign bus_a.in_shamt = tb_sh;    assign bus_b.in_shamt = tb_sh;
  assign bus_a.in_imm = tb_imm;     assign bus_b.in_imm = tb_imm;
  assign bus_a.in_last = tb_last;   assign bus_b.in_last = tb_last;

  instr_encoder_loader #(.ADDR_W(6), .MEMORY_DEPTH(64)) dut_a (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_a), .bus(bus_a),
    .count_o(cnt_a), .busy_o(busy_a), .done_o(done_a), .error_o(err_a));

  instr_encoder_loader #(.ADDR_W(2), .MEMORY_DEPTH(4)) dut_b (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_b), .bus(bus_b),
    .count_o(cnt_b), .busy_o(busy_b), .done_o(done_b), .error_o(err_b));

  always #5 clk = ~clk;

  logic        obs_ready, obs_we, obs_busy, obs_done, obs_error;
  logic [5:0]  obs_addr;
  logic [31:0] obs_wdata;
  logic [6:0]  obs_count;

  always_comb begin
    if (sel) begin
      obs_ready = bus_b.in_ready;  obs_we = bus_b.mem_we;
      obs_addr  = {4'd0, bus_b.mem_addr}; obs_wdata = bus_b.mem_wdata;
      obs_count = {4'd0, cnt_b};   obs_busy = busy_b; obs_done = done_b; obs_error = err_b;
    end else begin
      obs_ready = bus_a.in_ready;  obs_we = bus_a.mem_we;
      obs_addr  = bus_a.mem_addr;  obs_wdata = bus_a.mem_wdata;
      obs_count = cnt_a;           obs_busy = busy_a; obs_done = done_a; obs_error = err_a;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: program-level view (0 idle, 1 loading, 2 finished).
  int          m_state, m_slots, m_count, m_depth, e_addr;
  bit          m_err, e_we;
  logic [31:0] e_data;

  function automatic logic [31:0] ref_word(int kind, int rs, int rt, int rd, int sh, int imm);
    longint unsigned w;
    int functs[8] = '{32, 34, 36, 37, 39, 42, 0, 2};
    int ops[7]    = '{8, 13, 15, 35, 43, 4, 5};
    if (kind < 6)      w = rs * 2097152 + rt * 65536 + rd * 2048 + functs[kind];
    else if (kind < 8) w = rt * 65536 + rd * 2048 + sh * 64 + functs[kind];
    else if (kind == 10) w = longint'(ops[kind-8]) * 67108864 + rt * 65536 + imm;
    else               w = longint'(ops[kind-8]) * 67108864 + rs * 2097152 + rt * 65536 + imm;
    return w[31:0];
  endfunction

  task automatic model_reset();
    m_state = 0; m_slots = 0; m_count = 0; m_err = 1'b0; e_we = 1'b0; e_addr = 0; e_data = '0;
  endtask

  // One clock: check outputs, drive inputs, check ready, advance model, wait for next negedge.
  task automatic cyc(input bit st, input bit v, input int k, input int rs, input int rt,
                     input int rd, input int sh, input int imm, input bit last, output bit acc);
    bit rdy;
    chk_eq("mem_we", {31'd0, obs_we}, {31'd0, e_we});
    if (e_we) begin
      chk_eq("mem_addr", {26'd0, obs_addr}, e_addr);
      chk_eq("mem_wdata", obs_wdata, e_data);
    end
    chk_eq("count", {25'd0, obs_count}, m_count);
    chk_eq("busy", {31'd0, obs_busy}, {31'd0, m_state == 1});
    chk_eq("done", {31'd0, obs_done}, {31'd0, m_state == 2});
    chk_eq("error", {31'd0, obs_error}, {31'd0, m_err});
    tb_start = st; tb_valid = v; tb_kind = 4'(k); tb_rs = 5'(rs); tb_rt = 5'(rt);
    tb_rd = 5'(rd); tb_sh = 5'(sh); tb_imm = 16'(imm); tb_last = last;
    #1;
    rdy = (m_state == 1) && !st && (m_slots < m_depth);
    chk_eq("in_ready", {31'd0, obs_ready}, {31'd0, rdy});
    acc = v && rdy;
    m_count += int'(e_we);
    e_we = 1'b0;
    if (st) begin
      m_state = 1; m_slots = 0; m_count = 0; m_err = 1'b0;
    end else if (m_state == 1) begin
      if (acc) begin
        if (k == 15) m_err = 1'b1;
        else begin
          e_we = 1'b1; e_addr = m_slots; e_data = ref_word(k, rs, rt, rd, sh, imm); m_slots++;
        end
        if (last) m_state = 2;
      end else if (v && m_slots == m_depth) begin
        m_err = 1'b1; m_state = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bit a;
    cyc(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, a);
  endtask

  task automatic start();
    bit a;
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, a);
  endtask

  task automatic beat(input int k, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input bit last);
    bit a;
    cyc(1'b0, 1'b1, k, rs, rt, rd, sh, imm, last, a);
  endtask

  task automatic rand_prog(input int len);
    int sent = 0;
    bit a;
    start();
    for (int c = 0; c < 4 * len + 16 && sent < len && m_state == 1; c++) begin
      if ($urandom_range(3) != 0) begin
        int k = ($urandom_range(15) == 0) ? 15 : int'($urandom_range(14));
        cyc(1'b0, 1'b1, k, int'($urandom_range(31)), int'($urandom_range(31)),
            int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(65535)),
            sent == len - 1, a);
        if (a) sent++;
      end else begin
        idle();
      end
    end
    idle();
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; reset_ni = 1'b0; m_depth = 64;
    tb_start = 1'b0; tb_valid = 1'b0; tb_last = 1'b0; tb_kind = '0;
    tb_rs = '0; tb_rt = '0; tb_rd = '0; tb_sh = '0; tb_imm = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    chk_eq("rst_addr", {26'd0, obs_addr}, 32'd0);
    chk_eq("rst_wdata", obs_wdata, 32'd0);
    idle();
    beat(0, 1, 2, 3, 0, 0, 1'b0);           // ignored in IDLE
    idle();

    start();
    beat(8, 0, 8, 0, 0, 16'h0005, 1'b0);
    chk_eq("addi_word", obs_wdata, 32'h2008_0005);
    chk_eq("addi_addr", {26'd0, obs_addr}, 32'd0);
    idle();
    chk_eq("addi_count", {25'd0, obs_count}, 32'd1);

    start();
    beat(0, 8, 9, 10, 0, 0, 1'b0);
    chk_eq("add_word", obs_wdata, 32'h0109_5020);
    beat(10, 0, 1, 0, 0, 16'h1001, 1'b0);
    chk_eq("lui_word", obs_wdata, 32'h3C01_1001);
    chk_eq("lui_addr", {26'd0, obs_addr}, 32'd1);
    beat(6, 7, 3, 2, 4, 0, 1'b0);
    chk_eq("sll_word", obs_wdata, 32'h0003_1100);
    beat(13, 8, 9, 0, 0, 16'hFFFE, 1'b0);
    chk_eq("beq_word", obs_wdata, 32'h1109_FFFE);
    beat(12, 29, 9, 0, 0, 16'h0004, 1'b1);
    chk_eq("sw_word", obs_wdata, 32'hAFA9_0004);
    chk_eq("sw_done", {31'd0, obs_done}, 32'd1);
    beat(0, 1, 1, 1, 0, 0, 1'b0);           // ignored in DONE
    idle();

    start();
    beat(0, 1, 2, 3, 0, 0, 1'b0);
    beat(15, 1, 2, 3, 0, 0, 1'b0);
    beat(0, 4, 5, 6, 0, 0, 1'b0);
    chk_eq("illegal_err", {31'd0, obs_error}, 32'd1);
    chk_eq("after_illegal_addr", {26'd0, obs_addr}, 32'd1);
    beat(1, 4, 5, 6, 0, 0, 1'b0);
    start();                                 // drops progress, clears error
    idle();
    chk_eq("start_clr_err", {31'd0, obs_error}, 32'd0);

    for (int p = 0; p < 25; p++) rand_prog(int'($urandom_range(1, 20)));

    start();
    beat(9, 3, 4, 0, 0, 16'h00FF, 1'b0);
    chk_eq("pre_rst_we", {31'd0, obs_we}, 32'd1);
    reset_ni = 1'b0;
    #1;
    chk_eq("async_rst_we", {31'd0, obs_we}, 32'd0);
    chk_eq("async_rst_busy", {31'd0, obs_busy}, 32'd0);
    sel = 1'b1; m_depth = 4;
    model_reset();
    @(negedge clk);
    reset_ni = 1'b1;
    idle();

    start();
    for (int i = 0; i < 5; i++) beat(i % 14, i, i + 1, i + 2, 0, i, 1'b0);
    idle();
    chk_eq("ovf_count", {25'd0, obs_count}, 32'd4);
    chk_eq("ovf_error", {31'd0, obs_error}, 32'd1);
    chk_eq("ovf_done", {31'd0, obs_done}, 32'd1);

    for (int p = 0; p < 15; p++) rand_prog(int'($urandom_range(1, 7)));
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
